// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Word and address widths match the rest of the CPU datapath.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WAIT_W = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Returned in place of real data when a memory access times out.
  localparam word_t NOOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StIfetch,
    StDread,
    StDwrite,
    StResp
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the external memory port.
// The slave modport is the arbiter's view; master is the surrounding CPU and memory.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  addr_t inst_addr;
  word_t inst_data;
  logic  inst_ready;

  logic  data_read;
  logic  data_write;
  addr_t data_addr;
  word_t data_wdata;
  word_t data_rdata;
  logic  data_ready;

  logic  mem_req;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_ack;
  logic  mem_err;

  modport slave (
    input  inst_addr, data_read, data_write, data_addr, data_wdata, mem_rdata, mem_ack,
    output inst_data, inst_ready, data_rdata, data_ready, mem_req, mem_we, mem_addr,
           mem_wdata, mem_err
  );

  modport master (
    output inst_addr, data_read, data_write, data_addr, data_wdata, mem_rdata, mem_ack,
    input  inst_data, inst_ready, data_rdata, data_ready, mem_req, mem_we, mem_addr,
           mem_wdata, mem_err
  );

endinterface

// File: rtl/inst_line_buf.sv
// One-entry instruction buffer: a fill port, an address-matched invalidate port and a
// combinational hit against the current fetch address.
module inst_line_buf
  import mem_port_arbiter_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  wr_en_i,
  input  addr_t wr_addr_i,
  input  word_t wr_data_i,
  input  logic  inv_en_i,
  input  addr_t inv_addr_i,
  input  addr_t lookup_addr_i,
  output logic  hit_o,
  output word_t data_o
);

  logic  valid_q, valid_d;
  addr_t addr_q, addr_d;
  word_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      addr_d  = wr_addr_i;
      data_d  = wr_data_i;
    end else if (inv_en_i && (inv_addr_i == addr_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (addr_q == lookup_addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access
// in flight at a time, data before fetch, with a wait-cycle timeout per access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  addr_t             mem_addr_q, mem_addr_d;
  word_t             mem_wdata_q, mem_wdata_d;
  logic              data_ready_q, data_ready_d;
  word_t             data_rdata_q, data_rdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic              inst_hit;
  word_t             ibuf_data;
  logic              ibuf_wr;
  logic              ibuf_inv;
  logic [WAIT_W-1:0] wait_inc;
  logic              timeout;
  logic              done;
  word_t             resp_data;

  assign wait_inc  = wait_cnt_q + 1'b1;
  // Ack wins over a timeout landing on the same cycle.
  assign timeout   = !bus.mem_ack && (wait_inc == WAIT_W'(MAX_WAIT));
  assign done      = bus.mem_ack || timeout;
  assign resp_data = bus.mem_ack ? bus.mem_rdata : NOOP_WORD;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    data_ready_d = 1'b0;
    data_rdata_d = data_rdata_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    ibuf_wr      = 1'b0;
    ibuf_inv     = 1'b0;

    unique case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        if (bus.data_write) begin
          state_d     = StDwrite;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wdata;
        end else if (bus.data_read) begin
          state_d    = StDread;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.data_addr;
        end else if (!inst_hit) begin
          state_d    = StIfetch;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.inst_addr;
        end
      end
      StIfetch, StDread, StDwrite: begin
        if (done) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (timeout) mem_err_d = 1'b1;
          if (state_q == StIfetch) begin
            // Filled under the address actually fetched; a PC that moved meanwhile misses.
            ibuf_wr = 1'b1;
            state_d = StIdle;
          end else begin
            state_d      = StResp;
            data_ready_d = 1'b1;
            if (state_q == StDread) data_rdata_d = resp_data;
            else                    ibuf_inv     = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      data_ready_q <= 1'b0;
      data_rdata_q <= '0;
      wait_cnt_q   <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      data_ready_q <= data_ready_d;
      data_rdata_q <= data_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
    end
  end

  inst_line_buf u_inst_line_buf (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wr_en_i       (ibuf_wr),
    .wr_addr_i     (mem_addr_q),
    .wr_data_i     (resp_data),
    .inv_en_i      (ibuf_inv),
    .inv_addr_i    (mem_addr_q),
    .lookup_addr_i (bus.inst_addr),
    .hit_o         (inst_hit),
    .data_o        (ibuf_data)
  );

  assign bus.inst_ready = inst_hit;
  assign bus.inst_data  = ibuf_data;
  assign bus.data_ready = data_ready_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory with programmable ack latency,
// expected load/fetch words queued at stimulus time and compared on completion.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned MaxWait = 4;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks;
  int          errors;
  word_t       model [256];
  int          latency;
  bit          ack_auto;
  int          req_cycles;
  word_t       exp_data_q [$];
  word_t       exp_inst_q [$];
  logic [16:0] seen_q [$];
  logic        mon_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, input bit is_load, input int budget);
    int    n = 0;
    word_t exp;
    while (!bus.data_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(bus.data_ready), 32'h1);
    if (is_load) begin
      exp = exp_data_q.pop_front();
      if (bus.data_ready) check(tag, 32'(bus.data_rdata), 32'(exp));
    end
  endtask

  task automatic wait_inst(input string tag, input int budget);
    int    n = 0;
    word_t exp;
    while (!bus.inst_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    exp = exp_inst_q.pop_front();
    check({tag, "_hit"}, 32'(bus.inst_ready), 32'h1);
    if (bus.inst_ready) check(tag, 32'(bus.inst_data), 32'(exp));
  endtask

  // Memory: acks in the latency-th cycle that mem_req is seen high.
  initial begin
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (ack_auto) begin
        bus.mem_ack = 1'b0;
        if (rst_n && bus.mem_req) begin
          req_cycles++;
          if (req_cycles >= latency) begin
            bus.mem_ack = 1'b1;
            req_cycles  = 0;
            if (bus.mem_we) model[bus.mem_addr[7:0]] = bus.mem_wdata;
            else            bus.mem_rdata = model[bus.mem_addr[7:0]];
          end
        end else begin
          req_cycles = 0;
        end
      end
    end
  end

  // Log each new memory request as {we, addr}.
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req && !mon_prev) seen_q.push_back({bus.mem_we, bus.mem_addr});
      mon_prev = bus.mem_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [16:0] exp_seq [3];
    int          hi;
    int          k;
    int          rdy;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) model[i] = 16'(i * 257) ^ 16'h3C00;
    model[8'h10] = 16'h1234;
    model[8'h20] = 16'h5678;
    model[8'h30] = 16'h0330;
    model[8'h40] = 16'hA5A5;
    model[8'h50] = 16'h0550;

    latency        = 3;
    ack_auto       = 1'b1;
    rst_n          = 1'b0;
    bus.inst_addr  = 16'h0010;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.data_addr  = 16'h0000;
    bus.data_wdata = 16'h0000;
    bus.mem_rdata  = 16'h0000;
    bus.mem_ack    = 1'b0;
    step(2);

    check("rst_mem_req",    32'(bus.mem_req),    32'h0);
    check("rst_mem_we",     32'(bus.mem_we),     32'h0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'h0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'h0);
    check("rst_data_ready", 32'(bus.data_ready), 32'h0);
    check("rst_data_rdata", 32'(bus.data_rdata), 32'h0);
    check("rst_inst_ready", 32'(bus.inst_ready), 32'h0);
    check("rst_mem_err",    32'(bus.mem_err),    32'h0);

    // Post-reset fetch, latency 3: request in cycle 1, buffer filled in cycle 4.
    exp_inst_q.push_back(16'h1234);
    rst_n = 1'b1;
    step(1);
    check("fetch_req_c1", 32'(bus.mem_req),  32'h1);
    check("fetch_addr",   32'(bus.mem_addr), 32'h0010);
    check("fetch_we",     32'(bus.mem_we),   32'h0);
    step(2);
    check("fetch_pending_c3", 32'(bus.inst_ready), 32'h0);
    step(1);
    check("ibuf_fill_c4", 32'(bus.inst_ready), 32'h1);
    wait_inst("fetch_data", 5);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.mem_req) hi++;
    end
    check("pc_hold_no_req", 32'(hi), 32'h0);

    // Store over the buffered address invalidates it; refetch sees the new word.
    bus.data_write = 1'b1;
    bus.data_addr  = 16'h0010;
    bus.data_wdata = 16'hBEEF;
    exp_inst_q.push_back(16'hBEEF);
    step(1);
    check("store_req",   32'(bus.mem_req),   32'h1);
    check("store_we",    32'(bus.mem_we),    32'h1);
    check("store_addr",  32'(bus.mem_addr),  32'h0010);
    check("store_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    wait_ready("store", 1'b0, 20);
    check("store_inval", 32'(bus.inst_ready), 32'h0);
    bus.data_write = 1'b0;
    step(1);
    check("store_ready_pulse", 32'(bus.data_ready), 32'h0);
    wait_inst("refetch_beef", 20);

    // Load and fetch miss in the same idle cycle: load goes first.
    latency       = 2;
    bus.inst_addr = 16'h0020;
    bus.data_read = 1'b1;
    bus.data_addr = 16'h0040;
    exp_data_q.push_back(16'hA5A5);
    exp_inst_q.push_back(16'h5678);
    step(1);
    check("read_first_req",  32'(bus.mem_req),  32'h1);
    check("read_first_addr", 32'(bus.mem_addr), 32'h0040);
    check("read_first_we",   32'(bus.mem_we),   32'h0);
    wait_ready("load_data", 1'b1, 20);
    bus.data_read = 1'b0;
    step(1);
    check("load_ready_pulse", 32'(bus.data_ready), 32'h0);
    wait_inst("fetch_after_load", 20);

    // Load arriving mid-fetch waits; PC moved mid-fetch causes a fresh fetch.
    seen_q.delete();
    latency       = 3;
    bus.inst_addr = 16'h0030;
    step(1);
    check("ifetch_busy_addr", 32'(bus.mem_addr), 32'h0030);
    bus.inst_addr = 16'h0050;
    bus.data_read = 1'b1;
    bus.data_addr = 16'h0040;
    exp_data_q.push_back(16'hA5A5);
    exp_inst_q.push_back(16'h0550);
    step(1);
    check("read_waits_fetch", 32'(bus.mem_addr), 32'h0030);
    wait_ready("load_after_fetch", 1'b1, 30);
    bus.data_read = 1'b0;
    wait_inst("fetch_new_pc", 30);
    exp_seq = '{17'h00030, 17'h00040, 17'h00050};
    check("req_count", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("req_order_%0d", i),
            (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
    end

    // Load with no ack: aborts after MaxWait request cycles, returns zero, flags error.
    ack_auto      = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.data_read = 1'b1;
    bus.data_addr = 16'h0060;
    exp_data_q.push_back(NOOP_WORD);
    hi = 0;
    k  = 0;
    while (!bus.data_ready && k < 20) begin
      step(1);
      k++;
      if (bus.mem_req) hi++;
    end
    check("timeout_req_len", 32'(hi), 32'(MaxWait));
    wait_ready("timeout_rdata", 1'b1, 1);
    check("timeout_err", 32'(bus.mem_err), 32'h1);
    bus.data_read = 1'b0;
    ack_auto      = 1'b1;
    step(1);
    bus.data_read = 1'b1;
    bus.data_addr = 16'h0040;
    exp_data_q.push_back(16'hA5A5);
    wait_ready("load_post_timeout", 1'b1, 20);
    check("err_sticky", 32'(bus.mem_err), 32'h1);
    bus.data_read = 1'b0;
    step(1);

    // Reset in the middle of a store: request drops at once, no response afterwards.
    ack_auto       = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.data_write = 1'b1;
    bus.data_addr  = 16'h0070;
    bus.data_wdata = 16'h7777;
    step(1);
    check("dwrite_req", 32'(bus.mem_req), 32'h1);
    check("dwrite_we",  32'(bus.mem_we),  32'h1);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_req", 32'(bus.mem_req),    32'h0);
    check("reset_async_err", 32'(bus.mem_err),    32'h0);
    bus.data_write = 1'b0;
    exp_inst_q.push_back(16'h0550);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b1;
    step(1);
    bus.mem_ack = 1'b0;
    ack_auto    = 1'b1;
    rdy = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.data_ready) rdy++;
      step(1);
    end
    check("no_ready_after_reset", 32'(rdy), 32'h0);
    check("err_cleared_by_reset", 32'(bus.mem_err), 32'h0);
    wait_inst("fetch_after_reset", 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
